slot_scheduler: RTL and testbench
=================================

# slot_scheduler

Round-robin time-slot scheduler that shares one resource among N requesters, using an internal periodic tick as its timebase. A free-running prescaler generates a one-cycle `tick` every PRESCALE+1 clocks. Each grant lasts at most SLOT_TICKS ticks, then passes to the next requester. It sits between the pulse/timebase logic and any shared peripheral, such as a display mux or bus, that needs fair, time-bounded access.

## Interface
- `N`, 4: number of requesters, legal range 2..8.
- `WIDTH`, 16: prescaler counter width.
- `PRESCALE`, 16'd65535: tick period minus one; `tick` fires once every PRESCALE+1 cycles.
- `SLOT_TICKS`, 4: maximum grant length in ticks; a value of 0 is treated as 1.

- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk` only.
- `req`  in  N  level request per requester; must stay high while it wants or holds the resource.
- `done`  in  N  one-cycle early release from the current owner; ignored for non-owners.
- `grant`  out  N  registered one-hot grant; all zero when no owner.
- `owner`  out  3  registered binary index of the current owner; holds its last value when `busy`=0.
- `busy`  out  1  registered; high while any grant bit is set.
- `tick`  out  1  combinational; high for one cycle when prescaler count == PRESCALE.
- `expired`  out  1  registered one-cycle pulse; the slot ended by tick exhaustion.

## Operation
- Prescaler: WIDTH-bit `cnt`.
  - `tick` = (`cnt` == PRESCALE).
  - Next `cnt` = 0 if `tick`, else `cnt`+1.
  - Free-running regardless of arbiter state.
- Slot counter: `slot_cnt` has width ceil(log2(SLOT_TICKS+1)), minimum 1 bit.
  - Cleared on every new grant.
  - Increments on each `tick` while in GRANT.
- Round-robin pointer `last` = index of the most recent owner.
  - Search order is `last`+1, `last`+2, … modulo N.
  - The first set `req` bit in that order wins.
- State machine:
  - **IDLE**: if any `req` is set, register the winner into `grant`/`owner`, set `busy`, clear `slot_cnt`, set `last` = winner, go to GRANT. Otherwise stay in IDLE.
  - **GRANT**: release when any of the following holds:
    - `done[owner]` = 1;
    - `req[owner]` = 0;
    - `tick` = 1 with `slot_cnt` == SLOT_TICKS-1.
  - **GRANT release action**: clear `grant` and `busy`, go to GUARD. Pulse `expired` only when the release cause was tick exhaustion and `done[owner]` was 0.
  - **GUARD**: exactly one cycle with no grant. Arbitrate as in IDLE.
    - Winner found: go to GRANT.
    - No winner: go to IDLE.
- Reset, at any time including mid-grant:
  - `cnt`=0, `slot_cnt`=0, `last`=N-1 (so req[0] has first priority).
  - `grant`=0, `owner`=0, `busy`=0, `expired`=0, state=IDLE.
- Requesters other than the owner have no effect during GRANT. Requests arriving in GUARD are considered in that same GUARD cycle.

## Timing
- Request to grant latency: 1 cycle from IDLE. `req` sampled at edge k gives `grant` high after edge k+1.
- Release latency: 1 cycle. A release condition in cycle c clears `grant` after the edge ending c.
- Handoff gap: exactly one cycle (GUARD) with `grant`=0 between consecutive owners. The same owner may be re-granted after GUARD if it is the only requester.
- Simultaneous events:
  - `done` and the expiry `tick` in the same cycle: a normal release with `expired`=0.
  - `reset` and any other event: `reset` wins.
- Slot length: the grant ends on the SLOT_TICKS-th tick observed while granted. A partial period before the first tick counts toward no tick, so wall-clock slot length varies by up to PRESCALE+1 cycles.
- Wrap-around:
  - `cnt` returns to 0 after PRESCALE with no glitch.
  - `last` wraps N-1 → 0.
- `tick` after reset: first asserted at cycle index PRESCALE, counting from the first non-reset cycle as 0.

## Test plan
- **Reset and tick period.** PRESCALE=3, all `req`=0, release reset. Required: `tick` high at cycles 3, 7, 11; `grant`=0, `busy`=0, `expired`=0 throughout.
- **Single requester expiry.** SLOT_TICKS=2, `req`=4'b0100 held. Required:
  - `grant`=4'b0100 one cycle after `req`; `owner`=2.
  - `grant` drops after the 2nd tick, with one `expired` pulse.
  - One GUARD cycle, then re-grant to requester 2.
- **Round-robin fairness.** `req`=4'b1111 held, SLOT_TICKS=1. Required: grant order 0,1,2,3,0, each separated by one zero-grant cycle.
- **Early release.** Owner 1 pulses `done[1]` mid-slot. Required:
  - `grant` clears next edge; `expired`=0.
  - Next requester is granted after GUARD.
- **Done/expiry collision.** Pulse `done[owner]` in the same cycle as the expiring `tick`. Required: single release, `expired`=0.
- **Reset mid-grant.** Assert `reset` for one cycle while `grant`=4'b0010. Required:
  - All outputs zero after that edge and `cnt` restarts.
  - With `req`=4'b1010, the next grant goes to requester 1: `last`=3, so the search order is 0, 1, ….

Source files
------------

// File: rtl/slot_scheduler.sv
// slot_scheduler: round-robin time-slot arbiter for N requesters.
// A free-running prescaler produces a one-cycle tick every PRESCALE+1 clocks.
// Each grant lasts at most SLOT_TICKS ticks. A grant also ends early on
// done[owner] or when req[owner] drops. Every release is followed by exactly
// one no-grant GUARD cycle.
//
// Handshake: req is a level. A requester keeps req high while it waits for,
// or holds, the resource. grant is a registered one-hot "you own it now".
// done is a one-cycle release pulse; the block only looks at the bit that
// belongs to the current owner.
module slot_scheduler #(
    parameter int                N          = 4,
    parameter int                WIDTH      = 16,
    parameter logic [WIDTH-1:0]  PRESCALE   = 16'd65535,
    parameter int                SLOT_TICKS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] grant,
    output logic [2:0]   owner,
    output logic         busy,
    output logic         tick,
    output logic         expired
);

    // A SLOT_TICKS value of 0 behaves the same as 1.
    localparam int SLOT_EFF = (SLOT_TICKS < 1) ? 1 : SLOT_TICKS;
    localparam int SW_RAW   = $clog2(SLOT_TICKS + 1);
    localparam int SW       = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [SW-1:0]  slot_cnt_q, slot_cnt_d;
    logic [2:0]     last_q, last_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [2:0]     owner_q, owner_d;
    logic           busy_q, busy_d;
    logic           expired_q, expired_d;

    logic           own_req;
    logic           own_done;
    logic           slot_end;

    logic [7:0]     req_ext;
    logic [3:0]     arb_sum;
    logic           win_found;
    logic [2:0]     win_idx;

    // The tick comes straight from the count compare, so it is high in the same cycle as cnt == PRESCALE.
    assign tick = (cnt_q == PRESCALE);

    // Because grant is one-hot, masking with it picks out the owner's own req/done bits.
    assign own_req  = |(req & grant_q);
    assign own_done = |(done & grant_q);
    assign slot_end = tick && (slot_cnt_q == SLOT_LAST);

    // Prescaler next value: wrap to 0 on tick, otherwise count up.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + WIDTH'(1);
    end

    // Round-robin search from last+1 upward. The loop runs from the farthest
    // candidate to the nearest one, so the nearest set req is written last and wins.
    always_comb begin
        req_ext   = 8'(req);
        win_found = 1'b0;
        win_idx   = 3'd0;
        arb_sum   = 4'd0;
        for (int i = N; i >= 1; i--) begin
            arb_sum = {1'b0, last_q} + 4'(i);
            if (arb_sum >= 4'(N)) begin
                arb_sum = arb_sum - 4'(N);
            end
            if (req_ext[arb_sum[2:0]]) begin
                win_found = 1'b1;
                win_idx   = arb_sum[2:0];
            end
        end
    end

    // Next-state and next-output logic for the arbiter.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        expired_d  = 1'b0;
        slot_cnt_d = slot_cnt_q;
        last_d     = last_q;
        case (state_q)
            ST_GRANT: begin
                if (own_done || !own_req || slot_end) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    // If done arrives in the expiring cycle, treat it as a normal release.
                    expired_d = slot_end && !own_done;
                    state_d   = ST_GUARD;
                end else if (tick) begin
                    slot_cnt_d = slot_cnt_q + SW'(1);
                end
            end
            default: begin
                // IDLE and GUARD arbitrate the same way. GUARD falls back to IDLE when nobody is requesting.
                if (win_found) begin
                    for (int i = 0; i < N; i++) begin
                        grant_d[i] = (win_idx == 3'(i));
                    end
                    owner_d    = win_idx;
                    busy_d     = 1'b1;
                    slot_cnt_d = '0;
                    last_d     = win_idx;
                    state_d    = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Register all state. Reset has priority over every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            slot_cnt_q <= '0;
            last_q     <= 3'(N - 1);
            grant_q    <= '0;
            owner_q    <= 3'd0;
            busy_q     <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_cnt_q <= slot_cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            expired_q  <= expired_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_slot_scheduler.sv
// Testbench for slot_scheduler with N=4, PRESCALE=3 and SLOT_TICKS=2.
// The bench keeps a behavioural model based on cycle-phase arithmetic and an
// integer owner. A compare process checks the DUT against that model on every
// negative edge. Directed sections add hand-computed literal checks, and a
// randomized section follows them.
module tb_slot_scheduler;

    localparam int N  = 4;
    localparam int P  = 3;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant;
    logic [2:0]   owner;
    logic         busy;
    logic         tick;
    logic         expired;

    int n_cmp = 0;
    int n_err = 0;

    // clock
    always #5 clk = ~clk;

    slot_scheduler #(
        .N(N),
        .WIDTH(16),
        .PRESCALE(16'(P)),
        .SLOT_TICKS(ST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .done(done),
        .grant(grant),
        .owner(owner),
        .busy(busy),
        .tick(tick),
        .expired(expired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase is the number of cycles since reset, taken modulo P+1.
    // m_owner is -1 when no requester holds the grant.
    int m_phase, m_owner, m_last, m_ticks, m_shown;
    bit m_exp;
    bit m_valid = 1'b0;
    bit m_t;
    int m_pick;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_owner = -1; m_last = N - 1; m_ticks = 0;
            m_exp = 1'b0; m_shown = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_t     = (m_phase == P);
            m_phase = m_t ? 0 : m_phase + 1;
            m_exp   = 1'b0;
            if (m_owner >= 0) begin
                if (m_t) m_ticks++;
                if (done[m_owner] || !req[m_owner] || m_ticks == ST) begin
                    m_exp   = (m_ticks == ST) && !done[m_owner];
                    m_owner = -1;
                end
            end else begin
                m_pick = rr_pick(req, m_last);
                if (m_pick >= 0) begin
                    m_owner = m_pick; m_last = m_pick; m_shown = m_pick; m_ticks = 0;
                end
            end
        end
    end

    // compare process
    logic [31:0] e_grant;
    always @(negedge clk) begin
        if (m_valid) begin
            e_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
            chk("grant",   32'(grant),   e_grant);
            chk("busy",    32'(busy),    32'(m_owner >= 0));
            chk("owner",   32'(owner),   32'(m_shown));
            chk("expired", 32'(expired), 32'(m_exp));
            chk("tick",    32'(tick),    32'(m_phase == P));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // When this task returns, the bench is at the negedge of cycle 0 after reset is released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; done = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [N-1:0] prev_g;
    int zero_run;
    int got_q[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int budget;

    initial begin
        // Reset and tick period
        do_reset();
        for (int c = 0; c < 12; c++) begin
            chk("tick_period", 32'(tick), 32'((c == 3) || (c == 7) || (c == 11)));
            chk("idle_grant", 32'(grant), 32'd0);
            next_cycle();
        end

        // Single requester expiry (now at cycle 12)
        req = 4'b0100;
        next_cycle();                                // cycle 13
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_owner", 32'(owner), 32'd2);
        repeat (6) next_cycle();                     // cycle 19, second tick
        chk("single_hold", 32'(grant), 32'h4);
        next_cycle();                                // cycle 20, guard
        chk("single_drop", 32'(grant), 32'h0);
        chk("single_exp", 32'(expired), 32'd1);
        next_cycle();                                // cycle 21
        chk("single_regrant", 32'(grant), 32'h4);
        chk("single_exp_clr", 32'(expired), 32'd0);

        // Round-robin fairness
        do_reset();
        req = 4'b1111;
        prev_g = '0; zero_run = 1; got_q.delete(); budget = 400;
        while (got_q.size() < 5 && budget > 0) begin
            next_cycle();
            budget--;
            if (grant != 0 && prev_g == 0) begin
                got_q.push_back(int'(owner));
                if (got_q.size() > 1) chk("rr_gap", 32'(zero_run), 32'd1);
                zero_run = 0;
            end
            if (grant == 0) zero_run++;
            prev_g = grant;
        end
        chk("rr_timeout", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < got_q.size(); i++) begin
            chk("rr_order", 32'(got_q[i]), 32'(exp_order[i]));
        end

        // Early release
        do_reset();
        req = 4'b0110;
        next_cycle();                                // cycle 1
        chk("early_grant", 32'(grant), 32'h2);
        done = 4'b0010;
        next_cycle();                                // cycle 2
        done = '0;
        chk("early_drop", 32'(grant), 32'h0);
        chk("early_exp", 32'(expired), 32'd0);
        next_cycle();                                // cycle 3
        chk("early_next", 32'(grant), 32'h4);
        chk("early_owner", 32'(owner), 32'd2);

        // Done and expiring tick in the same cycle
        do_reset();
        req = 4'b0001;
        next_cycle();                                // cycle 1
        chk("coll_grant", 32'(grant), 32'h1);
        repeat (6) next_cycle();                     // cycle 7, expiring tick
        chk("coll_tick", 32'(tick), 32'd1);
        done = 4'b0001;
        next_cycle();                                // cycle 8
        done = '0;
        chk("coll_drop", 32'(grant), 32'h0);
        chk("coll_exp", 32'(expired), 32'd0);
        next_cycle();                                // cycle 9
        chk("coll_regrant", 32'(grant), 32'h1);
        chk("coll_exp2", 32'(expired), 32'd0);

        // Reset mid-grant
        do_reset();
        req = 4'b0010;
        next_cycle();                                // cycle 1
        chk("rst_pre", 32'(grant), 32'h2);
        reset = 1'b1; req = 4'b1010;
        next_cycle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_exp", 32'(expired), 32'd0);
        reset = 1'b0;                                // cycle 0
        next_cycle();                                // cycle 1
        chk("rst_next_grant", 32'(grant), 32'h2);
        chk("rst_next_owner", 32'(owner), 32'd1);
        repeat (2) next_cycle();                     // cycle 3
        chk("rst_tick_restart", 32'(tick), 32'd1);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7, 0) == 0) req[b] = ~req[b];
                done[b] = ($urandom_range(11, 0) == 0);
            end
            reset = ($urandom_range(299, 0) == 0);
            next_cycle();
        end
        reset = 1'b0; req = '0; done = '0;
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
